// File: rtl/lut_product_accumulator_64b.sv
// Sums blocks of BLOCK_LEN unsigned 64-bit products and hands each block sum out on a valid/ready port.
// Optional build macro LUT_ACC_SAT_EN: clamp the accumulator to all-ones on carry out instead of wrapping.
module lut_product_accumulator_64b #(
    parameter int ACC_W     = 72,
    parameter int COUNT_W   = 8,
    parameter int BLOCK_LEN = 16
) (
    input  logic               clk_32b,
    input  logic               resetn_32b,
    input  logic               product_valid,
    input  logic [63:0]        product_64b,
    output logic               product_ready,
    input  logic               flush,
    input  logic               clear,
    output logic               sum_valid,
    input  logic               sum_ready,
    output logic [ACC_W-1:0]   sum_acc,
    output logic [COUNT_W-1:0] sum_count,
    output logic               overflow,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [COUNT_W-1:0] BLOCK_CNT = COUNT_W'(BLOCK_LEN);

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [COUNT_W-1:0]   count;
    logic                 ovf;
    logic                 accept;
    logic [ACC_W:0]       acc_sum;
    logic [COUNT_W-1:0]   count_inc;

    // Bit ACC_W of the result is the carry out; the low bits are the new accumulator.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [63:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - 64){1'b0}}, p};
`ifdef LUT_ACC_SAT_EN
        if (s[ACC_W])
            s = {1'b1, {ACC_W{1'b1}}};
`endif
        return s;
    endfunction

    assign product_ready = (state != HOLD);
    assign accept        = product_valid & product_ready;
    assign acc_sum       = acc_add(acc, product_64b);
    assign count_inc     = count + 1'b1;

    assign sum_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign sum_acc   = acc;
    assign sum_count = count;
    assign overflow  = ovf;

    always_ff @(posedge clk_32b or negedge resetn_32b) begin
        if (!resetn_32b) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == HOLD) begin
            if (sum_ready) begin
                state <= IDLE;
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end else if (accept) begin
            // IDLE and ACCUM share this path since count is zero in IDLE.
            acc   <= acc_sum[ACC_W-1:0];
            count <= count_inc;
            ovf   <= ovf | acc_sum[ACC_W];
            state <= (count_inc == BLOCK_CNT || flush) ? HOLD : ACCUM;
        end else if (state == ACCUM && flush) begin
            state <= HOLD;
        end
    end

endmodule

// File: tb/tb_lut_product_accumulator_64b.sv
// Directed bench for lut_product_accumulator_64b: a 72-bit and a 64-bit instance share one stimulus stream.
module tb_lut_product_accumulator_64b;

    logic        clk_32b = 1'b0;
    logic        resetn_32b;
    logic        product_valid;
    logic [63:0] product_64b;
    logic        flush;
    logic        clear;
    logic        sum_ready;

    logic        ready_a, valid_a, ovf_a, busy_a;
    logic [71:0] acc_a;
    logic [7:0]  cnt_a;
    logic        ready_b, valid_b, ovf_b, busy_b;
    logic [63:0] acc_b;
    logic [7:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk_32b = ~clk_32b;

    lut_product_accumulator_64b #(.ACC_W(72), .COUNT_W(8), .BLOCK_LEN(4)) dut_a (
        .clk_32b(clk_32b), .resetn_32b(resetn_32b),
        .product_valid(product_valid), .product_64b(product_64b), .product_ready(ready_a),
        .flush(flush), .clear(clear),
        .sum_valid(valid_a), .sum_ready(sum_ready), .sum_acc(acc_a), .sum_count(cnt_a),
        .overflow(ovf_a), .busy(busy_a)
    );

    lut_product_accumulator_64b #(.ACC_W(64), .COUNT_W(8), .BLOCK_LEN(4)) dut_b (
        .clk_32b(clk_32b), .resetn_32b(resetn_32b),
        .product_valid(product_valid), .product_64b(product_64b), .product_ready(ready_b),
        .flush(flush), .clear(clear),
        .sum_valid(valid_b), .sum_ready(sum_ready), .sum_acc(acc_b), .sum_count(cnt_b),
        .overflow(ovf_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_32b);
        #1;
    endtask

    task automatic push(input logic [63:0] p, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            product_valid = 1'b1;
            product_64b   = p;
            flush         = (i == n - 1) ? f : 1'b0;
            step();
        end
        product_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic drain();
        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
    endtask

    logic [63:0] sat_exp;

    initial begin
`ifdef LUT_ACC_SAT_EN
        sat_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        sat_exp = 64'h0;
`endif
        resetn_32b    = 1'b0;
        product_valid = 1'b0;
        product_64b   = '0;
        flush         = 1'b0;
        clear         = 1'b0;
        sum_ready     = 1'b0;
        #12;
        check("rst_valid", {71'd0, valid_a}, 72'd0);
        check("rst_busy",  {71'd0, busy_a},  72'd0);
        check("rst_acc",   acc_a,            72'd0);
        check("rst_count", {64'd0, cnt_a},   72'd0);
        check("rst_ovf",   {71'd0, ovf_a},   72'd0);
        resetn_32b = 1'b1;
        step();
        check("rst_ready", {71'd0, ready_a}, 72'd1);

        // Full block of four products of 3.
        push(64'd3, 1'b0, 4);
        check("blk_valid", {71'd0, valid_a}, 72'd1);
        check("blk_acc",   acc_a,            72'd12);
        check("blk_count", {64'd0, cnt_a},   72'd4);
        check("blk_ovf",   {71'd0, ovf_a},   72'd0);
        check("blk_ready", {71'd0, ready_a}, 72'd0);
        drain();
        check("blk_done_valid", {71'd0, valid_a}, 72'd0);
        check("blk_done_busy",  {71'd0, busy_a},  72'd0);

        // Three all-ones products closed early by flush.
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3);
        check("fl_valid", {71'd0, valid_a}, 72'd1);
        check("fl_acc",   acc_a,            72'h2_FFFF_FFFF_FFFF_FFFD);
        check("fl_count", {64'd0, cnt_a},   72'd3);
        check("fl_ovf",   {71'd0, ovf_a},   72'd0);

        // Back-pressure on the sum port: nothing is absorbed.
        product_valid = 1'b1;
        product_64b   = 64'd5;
        flush         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_ready", {71'd0, ready_a}, 72'd0);
            check("hold_acc",   acc_a,            72'h2_FFFF_FFFF_FFFF_FFFD);
            check("hold_count", {64'd0, cnt_a},   72'd3);
        end
        product_valid = 1'b0;
        flush         = 1'b0;
        drain();
        check("hold_done_busy", {71'd0, busy_a}, 72'd0);

        // Carry out of the 64-bit instance; the 72-bit one absorbs it.
        push(64'h8000_0000_0000_0000, 1'b1, 2);
        check("ov64_acc",  {8'd0, acc_b},    {8'd0, sat_exp});
        check("ov64_ovf",  {71'd0, ovf_b},   72'd1);
        check("ov72_acc",  acc_a,            72'h1_0000_0000_0000_0000);
        check("ov72_ovf",  {71'd0, ovf_a},   72'd0);
        drain();

        // Flush with nothing accepted is ignored.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("empty_flush_busy", {71'd0, busy_a}, 72'd0);

        // Single product with flush from IDLE, then clear in HOLD.
        push(64'd7, 1'b1, 1);
        check("one_count", {64'd0, cnt_a},   72'd1);
        check("one_acc",   acc_a,            72'd7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_valid", {71'd0, valid_a}, 72'd0);
        check("clr_busy",  {71'd0, busy_a},  72'd0);
        check("clr_acc",   acc_a,            72'd0);
        push(64'd2, 1'b0, 4);
        check("after_clr_acc", acc_a, 72'd8);
        drain();

        // Asynchronous reset mid-block.
        push(64'd9, 1'b0, 2);
        check("mid_count", {64'd0, cnt_a}, 72'd2);
        #2;
        resetn_32b = 1'b0;
        #1;
        check("arst_acc",   acc_a,           72'd0);
        check("arst_count", {64'd0, cnt_a},  72'd0);
        check("arst_busy",  {71'd0, busy_a}, 72'd0);
        #3;
        resetn_32b = 1'b1;
        step();
        push(64'd1, 1'b0, 4);
        check("post_rst_acc",   acc_a,            72'd4);
        check("post_rst_valid", {71'd0, valid_a}, 72'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
